// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and phase decode for the intersection scheduler
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } signal_t;

  typedef enum logic [2:0] {
    HWY_GREEN    = 3'd0,
    HWY_YELLOW   = 3'd1,
    ALL_RED1     = 3'd2,
    CNTRY_GREEN  = 3'd3,
    CNTRY_YELLOW = 3'd4,
    ALL_RED2     = 3'd5,
    PED_WALK     = 3'd6
  } phase_t;

  typedef struct packed {
    signal_t hwy;
    signal_t cntry;
    logic    walk;
  } heads_t;

  // Moore decode of the phase register; anything unrecognised shows all red.
  function automatic heads_t decode_phase(input logic [2:0] ph);
    heads_t h;
    h.hwy   = RED;
    h.cntry = RED;
    h.walk  = 1'b0;
    case (ph)
      3'd0:    h.hwy   = GREEN;
      3'd1:    h.hwy   = YELLOW;
      3'd3:    h.cntry = GREEN;
      3'd4:    h.cntry = YELLOW;
      3'd6:    h.walk  = 1'b1;
      default: ;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/intersection_scheduler_if.sv
// rtl/intersection_scheduler_if.sv - sensor inputs and signal-head outputs of the scheduler
interface intersection_scheduler_if #(
  parameter int CNT_W = 8
);
  logic             cntry_car;
  logic             ped_req;
  logic [1:0]       hwy_signal;
  logic [1:0]       cntry_road_signal;
  logic             ped_walk;
  logic             ped_pending;
  logic [2:0]       phase_out;
  logic [CNT_W-1:0] timer_out;

  // Drives the sensors and observes the heads (environment side).
  modport master (
    output cntry_car, ped_req,
    input  hwy_signal, cntry_road_signal, ped_walk, ped_pending, phase_out, timer_out
  );

  // The scheduler itself.
  modport slave (
    input  cntry_car, ped_req,
    output hwy_signal, cntry_road_signal, ped_walk, ped_pending, phase_out, timer_out
  );
endinterface

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable saturating down-counter for phase dwell times
module phase_timer #(
  parameter int               CNT_W     = 8,
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired,
  output logic [CNT_W-1:0] count
);

  // Load on phase entry, otherwise count down and stick at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/intersection_scheduler.sv
// rtl/intersection_scheduler.sv - timed highway/country/pedestrian phase scheduler
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int CNT_W           = 8,
  parameter int HWY_MIN_GREEN   = 20,
  parameter int YELLOW_TIME     = 4,
  parameter int ALL_RED_TIME    = 2,
  parameter int CNTRY_MAX_GREEN = 15,
  parameter int PED_WALK_TIME   = 10
) (
  input logic                      clk,
  input logic                      reset_n,
  intersection_scheduler_if.slave  bus
);

  localparam int MAX_DUR = (1 << CNT_W) - 1;

  // Every dwell must fit the timer and be at least one cycle.
  if (HWY_MIN_GREEN < 1 || HWY_MIN_GREEN > MAX_DUR) begin : g_bad_hwy
    $error("HWY_MIN_GREEN out of range");
  end
  if (YELLOW_TIME < 1 || YELLOW_TIME > MAX_DUR) begin : g_bad_yel
    $error("YELLOW_TIME out of range");
  end
  if (ALL_RED_TIME < 1 || ALL_RED_TIME > MAX_DUR) begin : g_bad_red
    $error("ALL_RED_TIME out of range");
  end
  if (CNTRY_MAX_GREEN < 1 || CNTRY_MAX_GREEN > MAX_DUR) begin : g_bad_cg
    $error("CNTRY_MAX_GREEN out of range");
  end
  if (PED_WALK_TIME < 1 || PED_WALK_TIME > MAX_DUR) begin : g_bad_walk
    $error("PED_WALK_TIME out of range");
  end

  // Timer load values are duration-1 so a phase lasts exactly its duration.
  localparam logic [CNT_W-1:0] HWY_LOAD   = CNT_W'(HWY_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LOAD   = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] RED_LOAD   = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] CGRN_LOAD  = CNT_W'(CNTRY_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(PED_WALK_TIME - 1);

  phase_t           phase_q;
  phase_t           phase_d;
  logic             ped_pending_q;
  logic             expired;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] count;
  heads_t           heads;

  phase_timer #(
    .CNT_W     (CNT_W),
    .RESET_VAL (HWY_LOAD)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .expired  (expired),
    .count    (count)
  );

  // Phase register; reset always lands in highway green.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= HWY_GREEN;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Next-phase selection; pedestrian beats country car at the first all-red.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      HWY_GREEN:    if (expired && (bus.cntry_car || ped_pending_q)) phase_d = HWY_YELLOW;
      HWY_YELLOW:   if (expired) phase_d = ALL_RED1;
      ALL_RED1: begin
        if (expired) begin
          if (ped_pending_q)      phase_d = PED_WALK;
          else if (bus.cntry_car) phase_d = CNTRY_GREEN;
          else                    phase_d = HWY_GREEN;
        end
      end
      CNTRY_GREEN:  if (!bus.cntry_car || expired) phase_d = CNTRY_YELLOW;
      CNTRY_YELLOW: if (expired) phase_d = ALL_RED2;
      PED_WALK:     if (expired) phase_d = ALL_RED2;
      ALL_RED2:     if (expired) phase_d = HWY_GREEN;
      default:      phase_d = ALL_RED2;
    endcase
  end

  // Reload the dwell timer whenever a new phase is entered.
  always_comb begin
    load     = (phase_d != phase_q);
    load_val = RED_LOAD;
    case (phase_d)
      HWY_GREEN:                load_val = HWY_LOAD;
      HWY_YELLOW, CNTRY_YELLOW: load_val = YEL_LOAD;
      CNTRY_GREEN:              load_val = CGRN_LOAD;
      PED_WALK:                 load_val = WALK_LOAD;
      default:                  load_val = RED_LOAD;
    endcase
  end

  // Pedestrian latch: entering the walk clears it even if the button is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_pending_q <= 1'b0;
    end else if (phase_d == PED_WALK && phase_q != PED_WALK) begin
      ped_pending_q <= 1'b0;
    end else if (bus.ped_req && phase_q != PED_WALK) begin
      ped_pending_q <= 1'b1;
    end
  end

  assign heads                 = decode_phase(phase_q);
  assign bus.hwy_signal        = heads.hwy;
  assign bus.cntry_road_signal = heads.cntry;
  assign bus.ped_walk          = heads.walk;
  assign bus.ped_pending       = ped_pending_q;
  assign bus.phase_out         = phase_q;
  assign bus.timer_out         = count;

endmodule

// File: tb/tb_intersection_scheduler.sv
// tb/tb_intersection_scheduler.sv - scoreboard bench for intersection_scheduler
module tb_intersection_scheduler;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  intersection_scheduler_if #(.CNT_W(8)) bus ();

  intersection_scheduler #(
    .CNT_W           (8),
    .HWY_MIN_GREEN   (5),
    .YELLOW_TIME     (2),
    .ALL_RED_TIME    (1),
    .CNTRY_MAX_GREEN (4),
    .PED_WALK_TIME   (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    int ph;
    int tm;   // -1 means timer not checked
    int pend;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int ph2[21] = '{0,0,0,0,0,1,1,2,3,3,3,3,4,4,5,0,0,0,0,0,1};
  int tm2[21] = '{4,3,2,1,0,1,0,0,3,2,1,0,1,0,0,4,3,2,1,0,1};
  int ph3[14] = '{0,0,0,0,0,1,1,2,0,0,0,0,0,0};
  int ph4[28] = '{0,0,0,0,0,1,1,2,6,6,6,5,0,0,0,0,0,1,1,2,3,3,3,3,4,4,5,0};
  int pd4[28] = '{0,0,1,1,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
  int ph5[26] = '{0,0,0,0,0,1,1,2,6,6,6,5,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
  int pd5[26] = '{0,0,1,1,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
  int ph7[15] = '{0,0,0,0,0,1,1,2,3,3,4,4,5,0,0};
  int tm7[15] = '{4,3,2,1,0,1,0,0,3,2,1,0,0,4,3};

  function automatic int exp_hwy(input int ph);
    return (ph == 0) ? 2 : (ph == 1) ? 1 : 0;
  endfunction

  function automatic int exp_cntry(input int ph);
    return (ph == 3) ? 2 : (ph == 4) ? 1 : 0;
  endfunction

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: safety every cycle, scoreboard entry whenever one is queued.
  always @(negedge clk) begin
    int nonred;
    nonred = int'(bus.hwy_signal != 2'd0) + int'(bus.cntry_road_signal != 2'd0) + int'(bus.ped_walk);
    cmp("safety", int'(nonred <= 1), 1);
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("phase_out", int'(bus.phase_out), e.ph);
      cmp("hwy_signal", int'(bus.hwy_signal), exp_hwy(e.ph));
      cmp("cntry_road_signal", int'(bus.cntry_road_signal), exp_cntry(e.ph));
      cmp("ped_walk", int'(bus.ped_walk), int'(e.ph == 6));
      cmp("ped_pending", int'(bus.ped_pending), e.pend);
      if (e.tm >= 0) cmp("timer_out", int'(bus.timer_out), e.tm);
    end
  end

  task automatic go_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    bus.cntry_car = 1'b0;
    bus.ped_req = 1'b0;
    q.push_back('{0, 4, 0});
  endtask

  task automatic cyc(input logic car, input logic req, input int ph, input int tm, input int pend);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.cntry_car = car;
    bus.ped_req = req;
    q.push_back('{ph, tm, pend});
  endtask

  initial begin
    bus.cntry_car = 1'b0;
    bus.ped_req = 1'b0;

    // Idle: highway green holds, timer saturates at zero.
    go_reset();
    for (int c = 0; c < 50; c++) cyc(1'b0, 1'b0, 0, (c < 4) ? 4 - c : 0, 0);

    // Country car held: full cycle, max green enforced.
    go_reset();
    for (int c = 0; c < 21; c++) cyc(1'b1, 1'b0, ph2[c], tm2[c], 0);

    // Car withdraws before all-red expires: back to highway green.
    go_reset();
    for (int c = 0; c < 14; c++) cyc(c == 3 || c == 4, 1'b0, ph3[c], -1, 0);

    // Pedestrian beats waiting car; car served after one highway green.
    go_reset();
    for (int c = 0; c < 28; c++) cyc(1'b1, c == 1, ph4[c], -1, pd4[c]);

    // Button on the walk entry edge and during walk: no second walk.
    go_reset();
    for (int c = 0; c < 26; c++) cyc(1'b0, (c == 1) || (c >= 7 && c <= 10), ph5[c], -1, pd5[c]);

    // Reset mid country green drops the pending request.
    go_reset();
    for (int c = 0; c < 9; c++) cyc(1'b1, c == 8, (c < 5) ? 0 : (c < 7) ? 1 : (c == 7) ? 2 : 3, -1, 0);
    go_reset();
    for (int c = 0; c < 4; c++) cyc(1'b0, 1'b0, 0, 4 - c, 0);

    // Car drops mid country green: yellow on the next edge.
    go_reset();
    for (int c = 0; c < 15; c++) cyc(c < 9, 1'b0, ph7[c], tm7[c], 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/intersection_scheduler.md
# intersection_scheduler

Timed phase scheduler for the highway / country-road intersection. It replaces the untimed sensor-driven sequencer with parameterised dwell times: minimum highway green, fixed yellow, all-red clearance and maximum country green. It also arbitrates a latched pedestrian-crossing request against the country-road car sensor. It drives the two signal heads and the walk lamp directly and exports phase and timer for the top-level status logic.

## Interface
- CNT_W, 8, width of the dwell timer.
- HWY_MIN_GREEN, 20, minimum highway-green cycles.
- YELLOW_TIME, 4, yellow cycles, used for both roads.
- ALL_RED_TIME, 2, all-red clearance cycles.
- CNTRY_MAX_GREEN, 15, maximum country-green cycles.
- PED_WALK_TIME, 10, walk-lamp cycles.
- All durations must be in the range 1..2^CNT_W-1. Elaboration fails otherwise.

Ports (name, direction, width, meaning):
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cntry_car  in  1  country-road car sensor (level, already synchronised).
- ped_req  in  1  pedestrian button (pulse or level, already synchronised).
- hwy_signal  out  2  highway head: red=0, yellow=1, green=2.
- cntry_road_signal  out  2  country head, same encoding.
- ped_walk  out  1  walk lamp.
- ped_pending  out  1  latched, unserved pedestrian request.
- phase_out  out  3  current phase encoding.
- timer_out  out  CNT_W  current dwell timer value.

## Operation
- Phases and their encoding:
  - HWY_GREEN=0: hwy green, cntry red.
  - HWY_YELLOW=1: hwy yellow, cntry red.
  - ALL_RED1=2: both red.
  - CNTRY_GREEN=3: hwy red, cntry green.
  - CNTRY_YELLOW=4: hwy red, cntry yellow.
  - ALL_RED2=5: both red.
  - PED_WALK=6: both red, ped_walk=1.
  - Encoding 7 is illegal. It decodes as both heads red and goes to ALL_RED2 on the next edge.
- Timer behaviour:
  - On entry to a phase, the timer loads D-1, where D is that phase's duration.
  - It decrements each cycle and saturates at 0.
  - "expired" means timer==0.
- Transitions, evaluated on every rising edge:
  - HWY_GREEN → HWY_YELLOW when expired and (cntry_car or ped_pending). Otherwise stay; the timer holds at 0.
  - HWY_YELLOW → ALL_RED1 when expired.
  - ALL_RED1 → PED_WALK when expired and ped_pending. Otherwise → CNTRY_GREEN if cntry_car. Otherwise → HWY_GREEN (sensor withdrew).
  - CNTRY_GREEN → CNTRY_YELLOW when !cntry_car or expired. Dwell is at most CNTRY_MAX_GREEN cycles and at least 1.
  - CNTRY_YELLOW → ALL_RED2 when expired.
  - PED_WALK → ALL_RED2 when expired.
  - ALL_RED2 → HWY_GREEN when expired.
- Pedestrian latch (ped_pending):
  - Set by ped_req in any phase except PED_WALK; ignored during PED_WALK.
  - Cleared on the edge that enters PED_WALK. Clear beats a simultaneous ped_req on that edge.
- Priority at ALL_RED1: pedestrian over country car. A country car still waiting after a walk waits one full HWY_GREEN.
- Outputs hwy_signal, cntry_road_signal and ped_walk are a Moore decode of the phase register.
- Safety invariant: at most one of {hwy non-red, cntry non-red, ped_walk} is true in any cycle.

## Timing
- Reset (reset_n low), asynchronous:
  - phase=HWY_GREEN, timer=HWY_MIN_GREEN-1, ped_pending=0.
  - Hence hwy_signal=2, cntry_road_signal=0, ped_walk=0, phase_out=0.
- Reset release: the first decrement occurs on the first rising edge after reset_n goes high.
- Fixed phases (yellow, all-red, walk) last exactly D cycles.
- HWY_GREEN lasts at least HWY_MIN_GREEN cycles.
- Request latency: a request seen in the last HWY_GREEN cycle produces yellow on the next edge.
- Reset mid-phase: returns to HWY_GREEN immediately, even from CNTRY_GREEN or PED_WALK. The pending request is lost.
- Mid-green sensor drop: cntry_car falling in CNTRY_GREEN gives CNTRY_YELLOW on the next edge, regardless of timer value.

## Structure
- Package traffic_pkg holds:
  - signal_t enum (RED=0, YELLOW=1, GREEN=2).
  - phase_t enum (encodings above).
  - A function that decodes phase_t into head/walk outputs.
- Sub-module phase_timer: loadable CNT_W down-counter. Ports are load, load_val, expired and count; it saturates at 0. The scheduler instantiates it once.

## Test plan
All scenarios use HWY_MIN_GREEN=5, YELLOW_TIME=2, ALL_RED_TIME=1, CNTRY_MAX_GREEN=4, PED_WALK_TIME=3.
- Reset, no inputs for 50 cycles → phase_out stays 0, hwy_signal=2, timer_out reaches 0 after 4 edges and holds.
- cntry_car high from cycle 0 → phase sequence 0×5, 1×2, 2×1, 3×4, 4×2, 5×1, then 0; max green enforced.
- cntry_car pulse 2 cycles, released before ALL_RED1 expires → ALL_RED1 returns to phase 0; CNTRY_GREEN never entered.
- ped_req pulse at cycle 1 with cntry_car high → after ALL_RED1, phase 6 for 3 cycles with ped_walk=1; ped_pending clears on entry; then 5, then 0.
- ped_req asserted on the PED_WALK entry edge and during walk → ped_pending=0 after walk; no second walk.
- reset_n pulsed low mid-CNTRY_GREEN → outputs return to reset values combinationally. The safety-invariant assertion holds for the whole run.
